// File: rtl/condlogic_pw.sv
// condlogic_pw: ARM condition evaluation with per-group NZCV write enables,
// a CondEx latch that holds across multi-cycle instructions, write gating,
// and an optional Thumb-style IT block sequencer.
// Optional feature macro: CONDLOGIC_IT_EN (IT sequencer; off by default).
module condlogic_pw #(
  parameter int unsigned FLAG_GROUPS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [3:0]             Cond,
  input  logic [3:0]             ALUFlags,
  input  logic [FLAG_GROUPS-1:0] FlagW,
  input  logic                   PCS,
  input  logic                   NextPC,
  input  logic                   RegW,
  input  logic                   MemW,
  input  logic                   InstrStart,
  input  logic                   ITInstr,
  input  logic [3:0]             ITCond,
  input  logic [3:0]             ITMask,
  input  logic [2:0]             ITLen,
  output logic                   PCWrite,
  output logic                   RegWrite,
  output logic                   MemWrite,
  output logic                   CondEx,
  output logic [3:0]             Flags,
  output logic                   ITActive
);

  localparam int unsigned GW = 4 / FLAG_GROUPS;

  // Condition table over {N,Z,C,V}
  function automatic logic cond_eval(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    n  = f[3];
    z  = f[2];
    cy = f[1];
    v  = f[0];
    case (c)
      4'h0:    cond_eval = z;
      4'h1:    cond_eval = ~z;
      4'h2:    cond_eval = cy;
      4'h3:    cond_eval = ~cy;
      4'h4:    cond_eval = n;
      4'h5:    cond_eval = ~n;
      4'h6:    cond_eval = v;
      4'h7:    cond_eval = ~v;
      4'h8:    cond_eval = cy & ~z;
      4'h9:    cond_eval = ~cy | z;
      4'hA:    cond_eval = (n == v);
      4'hB:    cond_eval = (n != v);
      4'hC:    cond_eval = ~z & (n == v);
      4'hD:    cond_eval = z | (n != v);
      4'hE:    cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  logic [3:0]             eff_cond;
  logic                   cex_q;
  logic [FLAG_GROUPS-1:0] fw_q;
  logic                   wr_en;

`ifdef CONDLOGIC_IT_EN
  typedef enum logic {IT_IDLE, IT_ACTIVE} it_state_t;

  it_state_t  state;
  logic [1:0] idx;
  logic [2:0] rem;
  logic [3:0] it_cond;
  logic [3:0] it_mask;
  logic       it_instr_q;
  logic       it_blk;
  logic       it_start;

  // Slot condition: base or inverted base per mask bit; AL never inverts
  always_comb begin
    eff_cond = Cond;
    if (state == IT_ACTIVE) begin
      if (it_mask[idx] || (it_cond == 4'hE)) eff_cond = it_cond;
      else                                   eff_cond = it_cond ^ 4'b0001;
    end
  end

  // The IT instruction itself is write-suppressed for all of its cycles
  assign it_blk   = InstrStart ? (ITInstr & (state == IT_IDLE)) : it_instr_q;
  assign wr_en    = CondEx & ~it_blk;
  assign it_start = InstrStart & ITInstr & (state == IT_IDLE) & (ITLen != 3'd0) & CondEx;
  assign ITActive = (state == IT_ACTIVE);

  // IT sequencer: load on IT start, step one slot per InstrStart, end on last slot or taken branch
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IT_IDLE;
      idx        <= 2'd0;
      rem        <= 3'd0;
      it_cond    <= 4'd0;
      it_mask    <= 4'd0;
      it_instr_q <= 1'b0;
    end else begin
      if (InstrStart) it_instr_q <= ITInstr & (state == IT_IDLE);
      case (state)
        IT_IDLE: begin
          if (it_start) begin
            state   <= IT_ACTIVE;
            it_cond <= ITCond;
            it_mask <= ITMask;
            rem     <= ITLen;
            idx     <= 2'd0;
          end
        end
        IT_ACTIVE: begin
          if (wr_en && PCS) begin
            state <= IT_IDLE;
            rem   <= 3'd0;
          end else if (InstrStart) begin
            rem <= rem - 3'd1;
            idx <= idx + 2'd1;
            if (rem <= 3'd1) state <= IT_IDLE;
          end
        end
        default: state <= IT_IDLE;
      endcase
    end
  end
`else
  logic unused_it;

  // IT inputs have no effect in this build
  assign unused_it = ^{ITInstr, ITCond, ITMask, ITLen};
  assign eff_cond  = Cond;
  assign wr_en     = CondEx;
  assign ITActive  = 1'b0;
`endif

  // Effective condition: fresh on InstrStart, otherwise the latched value
  assign CondEx   = InstrStart ? cond_eval(eff_cond, Flags) : cex_q;

  // Write gating toward the datapath
  assign PCWrite  = NextPC | (wr_en & PCS);
  assign RegWrite = wr_en & RegW;
  assign MemWrite = wr_en & MemW;

  // CondEx latch, delayed flag-write enables and per-group NZCV update
  always_ff @(posedge clk) begin
    if (!reset) begin
      Flags <= 4'b0000;
      fw_q  <= '0;
      cex_q <= 1'b0;
    end else begin
      if (InstrStart) cex_q <= CondEx;
      fw_q <= FlagW & {FLAG_GROUPS{wr_en}};
      for (int unsigned g = 0; g < FLAG_GROUPS; g++) begin
        if (fw_q[g]) Flags[GW*g +: GW] <= ALUFlags[GW*g +: GW];
      end
    end
  end

endmodule

// File: tb/tb_condlogic_pw.sv
// Scoreboard bench for condlogic_pw: driver pushes expectations from a
// spec-level reference model (or hand constants), monitor pops and compares.
module tb_condlogic_pw;

  typedef struct packed {
    bit       rst_n;
    bit [3:0] cond;
    bit [3:0] alu;
    bit [1:0] fw;
    bit       pcs, nextpc, regw, memw, istart, itinstr;
    bit [3:0] itcond, itmask;
    bit [2:0] itlen;
  } stim_t;

  typedef struct packed {
    bit       pcw, rw, mw, cex;
    bit [3:0] flags;
    bit       itact;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] Cond, ALUFlags, ITCond, ITMask;
  logic [1:0] FlagW;
  logic       PCS, NextPC, RegW, MemW, InstrStart, ITInstr;
  logic [2:0] ITLen;
  logic       PCWrite, RegWrite, MemWrite, CondEx, ITActive;
  logic [3:0] Flags;

  condlogic_pw #(.FLAG_GROUPS(2)) dut (
    .clk(clk), .reset(reset), .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW),
    .PCS(PCS), .NextPC(NextPC), .RegW(RegW), .MemW(MemW), .InstrStart(InstrStart),
    .ITInstr(ITInstr), .ITCond(ITCond), .ITMask(ITMask), .ITLen(ITLen),
    .PCWrite(PCWrite), .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx),
    .Flags(Flags), .ITActive(ITActive)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errors = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  // Reference model state
  bit [3:0] m_flags = 4'b0;
  bit [1:0] m_pend  = 2'b0;
  bit       m_cex   = 1'b0;
  bit       m_itq   = 1'b0;
  bit [3:0] m_slots[$];

  // Conditions as ARM pairs: even code = base predicate, odd code = its inverse
  function automatic bit ref_cond(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      3'd6: base = !z && (n == v);
      default: base = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !base : base;
  endfunction

  function automatic exp_t mk(input bit pcw, rw, mw, cex, input bit [3:0] fl, input bit it);
    exp_t e;
    e.pcw = pcw; e.rw = rw; e.mw = mw; e.cex = cex; e.flags = fl; e.itact = it;
    return e;
  endfunction

  function automatic stim_t idle_s();
    stim_t s;
    s = '0;
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    reset = s.rst_n; Cond = s.cond; ALUFlags = s.alu; FlagW = s.fw;
    PCS = s.pcs; NextPC = s.nextpc; RegW = s.regw; MemW = s.memw;
    InstrStart = s.istart; ITInstr = s.itinstr; ITCond = s.itcond;
    ITMask = s.itmask; ITLen = s.itlen;
  endtask

  // One clock cycle: drive, predict this cycle's outputs, advance the model
  task automatic step(input stim_t s, input bit use_k = 1'b0, input exp_t k = '0,
                      input string tag = "rand");
    bit [3:0] eff;
    bit       in_it, cex, blk, wr;
    exp_t     e;
    @(posedge clk);
    #1;
    drive(s);
    in_it = (m_slots.size() > 0);
    eff   = (s.istart && in_it) ? m_slots[0] : s.cond;
    cex   = s.istart ? ref_cond(eff, m_flags) : m_cex;
`ifdef CONDLOGIC_IT_EN
    blk   = s.istart ? (s.itinstr && !in_it) : m_itq;
`else
    blk   = 1'b0;
`endif
    wr    = cex && !blk;
    e     = mk(s.nextpc | (wr & s.pcs), wr & s.regw, wr & s.memw, cex, m_flags, in_it);
    exp_q.push_back(use_k ? k : e);
    tag_q.push_back(tag);
    if (!s.rst_n) begin
      m_flags = 4'b0; m_pend = 2'b0; m_cex = 1'b0; m_itq = 1'b0;
      m_slots.delete();
    end else begin
      for (int g = 0; g < 2; g++)
        if (m_pend[g]) m_flags[2*g +: 2] = s.alu[2*g +: 2];
      m_pend = s.fw & {2{wr}};
      if (s.istart) m_cex = cex;
`ifdef CONDLOGIC_IT_EN
      if (s.istart) m_itq = blk;
      if (in_it) begin
        if (wr && s.pcs) m_slots.delete();
        else if (s.istart) void'(m_slots.pop_front());
      end else if (s.istart && s.itinstr && s.itlen != 3'd0 && cex) begin
        for (int i = 0; i < int'(s.itlen); i++)
          m_slots.push_back((s.itmask[i] || s.itcond == 4'hE) ? s.itcond : (s.itcond ^ 4'b0001));
      end
`endif
    end
  endtask

  // AL instruction writing both groups, then the value arrives from the ALU
  task automatic set_flags(input bit [3:0] v);
    stim_t s;
    s = idle_s(); s.istart = 1'b1; s.cond = 4'hE; s.fw = 2'b11;
    step(s);
    s = idle_s(); s.alu = v;
    step(s);
  endtask

  task automatic cmp(input string tag, input string fld, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s.%s: got %0d expected %0d at %0t", tag, fld, act, exp, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare mid-cycle against the queue
  initial begin
    exp_t  e;
    string t;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        cmp(t, "PCWrite",  int'(PCWrite),  int'(e.pcw));
        cmp(t, "RegWrite", int'(RegWrite), int'(e.rw));
        cmp(t, "MemWrite", int'(MemWrite), int'(e.mw));
        cmp(t, "CondEx",   int'(CondEx),   int'(e.cex));
        cmp(t, "Flags",    int'(Flags),    int'(e.flags));
        cmp(t, "ITActive", int'(ITActive), int'(e.itact));
      end
    end
  end

  initial begin
    stim_t s;
    // Bring-up reset, unchecked because pre-reset state is unknown
    s = idle_s(); s.rst_n = 1'b0;
    drive(s);
    repeat (2) @(posedge clk);

    // Reset with flag writes and write requests pending
    s = idle_s(); s.rst_n = 1'b0; s.fw = 2'b11; s.alu = 4'hF;
    s.regw = 1'b1; s.memw = 1'b1; s.pcs = 1'b1;
    repeat (2) step(s, 1'b1, mk(0, 0, 0, 0, 4'h0, 0), "reset");

    // Per-group flag writes: N,Z group then C,V group
    s = idle_s(); s.istart = 1'b1; s.cond = 4'hE; s.fw = 2'b10;
    step(s, 1'b0, '0, "grp_wr");
    s = idle_s(); s.alu = 4'b0100;
    step(s, 1'b0, '0, "grp_wr");
    s = idle_s(); s.fw = 2'b01;
    step(s, 1'b1, mk(0, 0, 0, 1, 4'b0100, 0), "grp_hi");
    s = idle_s(); s.alu = 4'b1011;
    step(s, 1'b0, '0, "grp_wr");
    s = idle_s();
    step(s, 1'b1, mk(0, 0, 0, 1, 4'b0111, 0), "grp_lo");

    // Latched CondEx: EQ taken with Z=1, then Z cleared mid-instruction
    s = idle_s(); s.istart = 1'b1; s.cond = 4'h0; s.fw = 2'b10; s.regw = 1'b1;
    step(s, 1'b1, mk(0, 1, 0, 1, 4'b0111, 0), "latch_start");
    s = idle_s(); s.alu = 4'b0000; s.regw = 1'b1;
    step(s, 1'b0, '0, "latch");
    s = idle_s(); s.regw = 1'b1;
    repeat (3) step(s, 1'b1, mk(0, 1, 0, 1, 4'b0011, 0), "latch_hold");

    // Suppression: NE with Z=1 blocks PC/memory/flag writes
    set_flags(4'b0100);
    s = idle_s(); s.istart = 1'b1; s.cond = 4'h1; s.pcs = 1'b1; s.memw = 1'b1; s.fw = 2'b11;
    step(s, 1'b1, mk(0, 0, 0, 0, 4'b0100, 0), "supp");
    s = idle_s(); s.alu = 4'b1011; s.pcs = 1'b1; s.memw = 1'b1;
    step(s, 1'b1, mk(0, 0, 0, 0, 4'b0100, 0), "supp");
    s = idle_s(); s.pcs = 1'b1; s.nextpc = 1'b1;
    step(s, 1'b1, mk(1, 0, 0, 0, 4'b0100, 0), "supp_nextpc");

    // All 16 codes against all 16 flag values
    for (int f = 0; f < 16; f++) begin
      set_flags(4'(f));
      for (int c = 0; c < 16; c++) begin
        s = idle_s(); s.istart = 1'b1; s.cond = 4'(c); s.alu = 4'($urandom);
        s.regw = 1'b1;
        if (c == 15) step(s, 1'b1, mk(0, 0, 0, 0, 4'(f), 0), "cond_nv");
        else         step(s, 1'b0, '0, "cond_sweep");
      end
    end

`ifdef CONDLOGIC_IT_EN
    // IT EQ, mask 0101, length 3, with Z=1
    set_flags(4'b0100);
    for (int run = 0; run < 2; run++) begin
      s = idle_s(); s.istart = 1'b1; s.cond = 4'hE; s.itinstr = 1'b1; s.regw = 1'b1;
      s.itcond = 4'h0; s.itmask = 4'b0101; s.itlen = 3'd3;
      step(s, 1'b1, mk(0, 0, 0, 1, 4'b0100, 0), "it_instr");
      s = idle_s(); s.regw = 1'b1;
      step(s, 1'b1, mk(0, 0, 0, 1, 4'b0100, 1), "it_instr_tail");
      if (run == 0) begin
        for (int k = 0; k < 3; k++) begin
          s = idle_s(); s.istart = 1'b1; s.cond = 4'hE; s.regw = 1'b1;
          step(s, 1'b1, mk(0, (k != 1), 0, (k != 1), 4'b0100, 1), "it_slot");
          s = idle_s(); s.regw = 1'b1;
          step(s, 1'b0, '0, "it_slot_tail");
        end
        s = idle_s(); s.regw = 1'b1;
        step(s, 1'b1, mk(0, 1, 0, 1, 4'b0100, 0), "it_done");
      end else begin
        s = idle_s(); s.istart = 1'b1; s.cond = 4'hE; s.pcs = 1'b1;
        step(s, 1'b1, mk(1, 0, 0, 1, 4'b0100, 1), "it_branch");
        s = idle_s();
        step(s, 1'b1, mk(0, 0, 0, 1, 4'b0100, 0), "it_branch_end");
      end
    end
`endif

    // Randomized traffic including occasional resets and IT instructions
    for (int i = 0; i < 3000; i++) begin
      s.rst_n   = ($urandom_range(0, 63) != 0);
      s.cond    = 4'($urandom);
      s.alu     = 4'($urandom);
      s.fw      = 2'($urandom);
      s.pcs     = ($urandom_range(0, 3) == 0);
      s.nextpc  = ($urandom_range(0, 3) == 0);
      s.regw    = 1'($urandom);
      s.memw    = 1'($urandom);
      s.istart  = ($urandom_range(0, 2) == 0);
      s.itinstr = ($urandom_range(0, 7) == 0);
      s.itcond  = 4'($urandom);
      s.itmask  = 4'($urandom);
      s.itlen   = 3'($urandom_range(0, 4));
      step(s);
    end

    // Drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
